// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and round datapath functions.
// Byte b of a state (FIPS-197 order) lives at flat bits [127-8b -: 8].
package aes_pkg;

   typedef logic [3:0][3:0][7:0] state_t;
   typedef logic [3:0][7:0]      word_t;
   typedef logic [7:0]           bytes_t [16];

   localparam int unsigned NR_128 = 10;

   typedef enum logic [1:0] {IDLE, RUN, DONE} ctrl_e;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] rcon(input logic [3:0] round);
      case (round)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic bytes_t to_bytes(input state_t s);
      bytes_t r;
      for (int unsigned b = 0; b < 16; b++) r[b] = s[3 - b / 4][3 - b % 4];
      return r;
   endfunction

   function automatic state_t from_bytes(input bytes_t v);
      state_t r;
      for (int unsigned b = 0; b < 16; b++) r[3 - b / 4][3 - b % 4] = v[b];
      return r;
   endfunction

   function automatic word_t sub_word(input word_t w);
      word_t r;
      for (int unsigned i = 0; i < 4; i++) r[i] = SBOX[w[i]];
      return r;
   endfunction

   function automatic state_t sub_bytes(input state_t s);
      state_t r;
      for (int unsigned c = 0; c < 4; c++) r[c] = sub_word(s[c]);
      return r;
   endfunction

   function automatic bytes_t shift_rows(input bytes_t v);
      bytes_t r;
      for (int unsigned c = 0; c < 4; c++)
         for (int unsigned rw = 0; rw < 4; rw++)
            r[4 * c + rw] = v[4 * ((c + rw) % 4) + rw];
      return r;
   endfunction

   function automatic bytes_t mix_columns(input bytes_t v);
      bytes_t r;
      for (int unsigned c = 0; c < 4; c++) begin
         r[4*c]   = xtime(v[4*c]) ^ xtime(v[4*c+1]) ^ v[4*c+1] ^ v[4*c+2] ^ v[4*c+3];
         r[4*c+1] = v[4*c] ^ xtime(v[4*c+1]) ^ xtime(v[4*c+2]) ^ v[4*c+2] ^ v[4*c+3];
         r[4*c+2] = v[4*c] ^ v[4*c+1] ^ xtime(v[4*c+2]) ^ xtime(v[4*c+3]) ^ v[4*c+3];
         r[4*c+3] = xtime(v[4*c]) ^ v[4*c] ^ v[4*c+1] ^ v[4*c+2] ^ xtime(v[4*c+3]);
      end
      return r;
   endfunction

   function automatic state_t aes_round(input state_t st, input state_t rk);
      return from_bytes(mix_columns(shift_rows(to_bytes(sub_bytes(st))))) ^ rk;
   endfunction

   function automatic state_t aes_reduced_round(input state_t st, input state_t rk);
      return from_bytes(shift_rows(to_bytes(sub_bytes(st)))) ^ rk;
   endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: current round key plus Rcon to the next round key.
import aes_pkg::*;

module aes_key_step (
   input  logic [3:0][3:0][7:0] rk,
   input  logic [7:0]           rcon,
   output logic [3:0][3:0][7:0] rk_n
);

   word_t w0, w1, w2, w3;
   word_t rot, tmp;
   word_t n0, n1, n2, n3;

   always_comb begin
      w0   = rk[3];
      w1   = rk[2];
      w2   = rk[1];
      w3   = rk[0];
      // RotWord: leading byte of w3 moves to the end
      rot  = {w3[2], w3[1], w3[0], w3[3]};
      tmp  = sub_word(rot) ^ {rcon, 24'h000000};
      n0   = w0 ^ tmp;
      n1   = w1 ^ n0;
      n2   = w2 ^ n1;
      n3   = w3 ^ n2;
      rk_n = {n0, n1, n2, n3};
   end

endmodule

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryptor: one round per cycle, key expanded on the fly,
// valid/ready on both sides.
import aes_pkg::*;

module aes128_iter_ctrl #(
   parameter int unsigned NR    = 10,
   parameter int unsigned CNT_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3:0][3:0][7:0] in_key,
   input  logic [3:0][3:0][7:0] in_pt,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [3:0][3:0][7:0] out_ct,
   output logic                 busy,
   output logic [CNT_W-1:0]     blk_cnt
);

   generate
      if (NR != NR_128) begin : g_bad_nr
         $error("aes128_iter_ctrl: only NR=10 is supported");
      end
   endgenerate

   localparam logic [3:0] LAST_ROUND = 4'(NR);

   ctrl_e      state;
   logic [3:0] round;
   state_t     st;
   state_t     rk;
   state_t     rk_n;
   state_t     st_mid;
   state_t     st_fin;

   aes_key_step u_key_step (
      .rk   (rk),
      .rcon (rcon(round)),
      .rk_n (rk_n)
   );

   always_comb begin
      st_mid = aes_round(st, rk_n);
      st_fin = aes_reduced_round(st, rk_n);
   end

   assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         round     <= '0;
         st        <= '0;
         rk        <= '0;
         out_valid <= 1'b0;
         out_ct    <= '0;
         blk_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  st    <= in_pt ^ in_key;
                  rk    <= in_key;
                  round <= 4'd1;
                  state <= RUN;
               end
            end
            RUN: begin
               rk    <= rk_n;
               round <= round + 4'd1;
               if (round == LAST_ROUND) begin
                  st        <= st_fin;
                  out_ct    <= st_fin;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  st <= st_mid;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  blk_cnt   <= blk_cnt + CNT_W'(1);
                  // A pair offered in the handshake cycle starts immediately, as from IDLE
                  if (in_valid) begin
                     st    <= in_pt ^ in_key;
                     rk    <= in_key;
                     round <= 4'd1;
                     state <= RUN;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Self-checking bench for aes128_iter_ctrl using FIPS-197 vectors and a result scoreboard.
module tb_aes128_iter_ctrl;

   localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] K2 = 128'h0;
   localparam logic [127:0] P2 = 128'h0;
   localparam logic [127:0] C2 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   logic                 clk;
   logic                 rst_n;
   logic                 in_valid;
   logic                 in_ready;
   logic [3:0][3:0][7:0] in_key;
   logic [3:0][3:0][7:0] in_pt;
   logic                 out_valid;
   logic                 out_ready;
   logic [3:0][3:0][7:0] out_ct;
   logic                 busy;
   logic [31:0]          blk_cnt;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_cnt = 0;
   logic [127:0] sbq [$];

   aes128_iter_ctrl #(.NR(10), .CNT_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_key    (in_key),
      .in_pt     (in_pt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ct    (out_ct),
      .busy      (busy),
      .blk_cnt   (blk_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] exp);
      in_valid = 1'b1;
      in_key   = key;
      in_pt    = pt;
      sbq.push_back(exp);
   endtask

   task automatic wait_out(input int max, output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         if (out_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         cyc();
         n++;
      end
   endtask

   function automatic logic [127:0] pop_exp();
      if (sbq.size() == 0) return 128'hx;
      return sbq.pop_front();
   endfunction

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_key    = '0;
      in_pt     = '0;
      repeat (3) cyc();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++;
      if (out_ct !== 128'h0) begin errors++; $display("FAIL reset_out_ct: got %h expected 0", out_ct); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++;
      if (blk_cnt !== 32'd0) begin errors++; $display("FAIL reset_blk_cnt: got %0d expected 0", blk_cnt); end
      rst_n = 1'b1;
      cyc();
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_latency();
      int n;
      bit ok;
      logic [127:0] e;
      offer(K1, P1, C1);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_in_ready: got %b expected 1", in_ready); end
      cyc();
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++; $display("FAIL lat_run_flags: got busy=%b in_ready=%b expected busy=1 in_ready=0", busy, in_ready);
      end
      wait_out(30, n, ok);
      checks++;
      if (!ok || n != 10) begin errors++; $display("FAIL lat_cycles: got %0d edges after accept (seen=%0d) expected 10", n, ok); end
      e = pop_exp();
      checks++;
      if (out_ct !== e) begin errors++; $display("FAIL lat_ct: got %h expected %h", out_ct, e); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL lat_done_in_ready: got %b expected 0", in_ready); end
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      exp_cnt++;
      checks++;
      if (blk_cnt !== exp_cnt || out_valid !== 1'b0) begin
         errors++; $display("FAIL lat_handshake: got cnt=%0d valid=%b expected cnt=%0d valid=0", blk_cnt, out_valid, exp_cnt);
      end
   endtask

   task automatic test_zero_vector();
      int n;
      bit ok;
      logic [127:0] e;
      out_ready = 1'b1;
      offer(K2, P2, C2);
      cyc();
      in_valid = 1'b0;
      wait_out(30, n, ok);
      e = pop_exp();
      checks++;
      if (!ok || out_ct !== e) begin errors++; $display("FAIL zero_ct: got %h expected %h (seen=%0d)", out_ct, e, ok); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_done_in_ready: got %b expected 1", in_ready); end
      cyc();
      exp_cnt++;
      checks++;
      if (blk_cnt !== exp_cnt) begin errors++; $display("FAIL zero_blk_cnt: got %0d expected %0d", blk_cnt, exp_cnt); end
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL zero_idle: got busy=%b valid=%b expected 0 0", busy, out_valid);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int n;
      bit ok;
      logic [127:0] e;
      offer(K1, P1, C1);
      cyc();
      in_valid = 1'b0;
      wait_out(30, n, ok);
      e = pop_exp();
      checks++;
      if (!ok || out_ct !== e) begin errors++; $display("FAIL bp_ct: got %h expected %h (seen=%0d)", out_ct, e, ok); end
      for (int i = 0; i < 20; i++) begin
         cyc();
         checks++;
         if (out_valid !== 1'b1 || out_ct !== e || in_ready !== 1'b0 || blk_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got valid=%b ct=%h in_ready=%b cnt=%0d expected 1 %h 0 %0d",
                     i, out_valid, out_ct, in_ready, blk_cnt, e, exp_cnt);
         end
      end
      out_ready = 1'b1;
      cyc();
      exp_cnt++;
      checks++;
      if (blk_cnt !== exp_cnt) begin errors++; $display("FAIL bp_release_cnt: got %0d expected %0d", blk_cnt, exp_cnt); end
      repeat (3) cyc();
      checks++;
      if (blk_cnt !== exp_cnt) begin errors++; $display("FAIL bp_once_cnt: got %0d expected %0d", blk_cnt, exp_cnt); end
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int n1, n2;
      bit ok1, ok2;
      logic [127:0] e;
      out_ready = 1'b1;
      offer(K1, P1, C1);
      cyc();
      in_key = K2;
      in_pt  = P2;
      wait_out(30, n1, ok1);
      checks++;
      if (!ok1 || n1 != 10) begin errors++; $display("FAIL b2b_first_lat: got %0d expected 10 (seen=%0d)", n1, ok1); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b expected 1", in_ready); end
      sbq.push_back(C2);
      e = pop_exp();
      checks++;
      if (out_ct !== e) begin errors++; $display("FAIL b2b_first_ct: got %h expected %h", out_ct, e); end
      cyc();
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_reload: got busy=%b valid=%b expected 1 0", busy, out_valid);
      end
      wait_out(30, n2, ok2);
      checks++;
      if (!ok2 || n2 + 1 != 11) begin errors++; $display("FAIL b2b_gap: got %0d cycles expected 11 (seen=%0d)", n2 + 1, ok2); end
      e = pop_exp();
      checks++;
      if (out_ct !== e) begin errors++; $display("FAIL b2b_second_ct: got %h expected %h", out_ct, e); end
      cyc();
      exp_cnt += 2;
      checks++;
      if (blk_cnt !== exp_cnt) begin errors++; $display("FAIL b2b_blk_cnt: got %0d expected %0d", blk_cnt, exp_cnt); end
      out_ready = 1'b0;
   endtask

   task automatic test_ignore_run();
      bit ok;
      logic [127:0] e;
      offer(K1, P1, C1);
      cyc();
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (out_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         in_valid = 1'($urandom_range(0, 1));
         in_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
         in_pt    = {$urandom(), $urandom(), $urandom(), $urandom()};
         cyc();
      end
      in_valid = 1'b0;
      e = pop_exp();
      checks++;
      if (!ok || out_ct !== e) begin errors++; $display("FAIL ign_ct: got %h expected %h (seen=%0d)", out_ct, e, ok); end
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      exp_cnt++;
      checks++;
      if (blk_cnt !== exp_cnt || busy !== 1'b0) begin
         errors++; $display("FAIL ign_after: got cnt=%0d busy=%b expected %0d 0", blk_cnt, busy, exp_cnt);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      bit ok;
      logic [127:0] e;
      offer(K1, P1, C1);
      cyc();
      in_valid = 1'b0;
      repeat (4) cyc();
      rst_n = 1'b0;
      #1;
      void'(sbq.pop_back());
      exp_cnt = 0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL midrst_flags: got valid=%b busy=%b expected 0 0", out_valid, busy);
      end
      checks++;
      if (blk_cnt !== 32'd0) begin errors++; $display("FAIL midrst_blk_cnt: got %0d expected 0", blk_cnt); end
      checks++;
      if (out_ct !== 128'h0) begin errors++; $display("FAIL midrst_out_ct: got %h expected 0", out_ct); end
      cyc();
      rst_n = 1'b1;
      repeat (12) begin
         cyc();
         checks++;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_partial: got valid=%b expected 0", out_valid); end
      end
      out_ready = 1'b1;
      offer(K1, P1, C1);
      cyc();
      in_valid = 1'b0;
      wait_out(30, n, ok);
      e = pop_exp();
      checks++;
      if (!ok || n != 10 || out_ct !== e) begin
         errors++; $display("FAIL midrst_fresh: got ct=%h n=%0d expected %h n=10", out_ct, n, e);
      end
      cyc();
      exp_cnt++;
      checks++;
      if (blk_cnt !== exp_cnt) begin errors++; $display("FAIL midrst_blk_cnt_after: got %0d expected %0d", blk_cnt, exp_cnt); end
      out_ready = 1'b0;
      checks++;
      if (sbq.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", sbq.size()); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_zero_vector();
      test_backpressure();
      test_back_to_back();
      test_ignore_run();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
